// File: rtl/key_sequence_decoder.sv
// Serial command-key decoder: checks an MSB-first unlock key, then captures
// a mode word. Failed or aborted commands raise err and bump a consecutive
// failure count; reaching MAX_FAILS locks the block until reset.
module key_sequence_decoder #(
  parameter int                 KEY_WIDTH  = 4,
  parameter logic [KEY_WIDTH-1:0] KEY_VALUE = 4'b1010,
  parameter int                 MODE_WIDTH = 1,
  parameter int                 MAX_FAILS  = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            input_key,
  input  logic                            valid_cmd,
  output logic                            active,
  output logic [MODE_WIDTH-1:0]           mode,
  output logic                            err,
  output logic                            locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]  fail_cnt
);

  localparam int CW = $clog2(KEY_WIDTH + MODE_WIDTH + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [CW-1:0] KEY_LAST = CW'(KEY_WIDTH);
  localparam logic [CW-1:0] CMD_LAST = CW'(KEY_WIDTH + MODE_WIDTH);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_MODE, S_DONE, S_FAIL, S_LOCK
  } state_t;

  state_t                r_state;
  logic [KEY_WIDTH-1:0]  r_key;
  logic [MODE_WIDTH-1:0] r_msh;
  logic [CW-1:0]         r_cnt;

  logic [KEY_WIDTH-1:0]  w_key_base;
  logic [KEY_WIDTH-1:0]  w_key_next;
  logic [MODE_WIDTH-1:0] w_mode_next;
  logic [CW-1:0]         w_cnt_next;
  logic [FW-1:0]         w_fail_inc;
  logic                  w_key_phase;
  logic                  w_fail;

  // Next shift values; IDLE starts from an empty word so the first sampled
  // bit lands cleanly even when KEY_WIDTH is 1.
  always_comb begin
    w_key_phase = (r_state == S_IDLE) || (r_state == S_KEY);
    w_key_base  = (r_state == S_IDLE) ? '0 : r_key;
    w_key_next  = (w_key_base << 1) | KEY_WIDTH'(input_key);
    w_mode_next = (r_msh << 1) | MODE_WIDTH'(input_key);
    w_cnt_next  = ((r_state == S_IDLE) ? '0 : r_cnt) + CW'(1);
    w_fail_inc  = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + FW'(1);
    w_fail      = 1'b0;
    if ((r_state == S_KEY || r_state == S_MODE) && !valid_cmd)
      w_fail = 1'b1;
    else if (w_key_phase && valid_cmd && w_cnt_next == KEY_LAST &&
             w_key_next != KEY_VALUE)
      w_fail = 1'b1;
  end

  // Command FSM with registered outputs; a failure overrides the per-state
  // next-state choice at the bottom of the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_key    <= '0;
      r_msh    <= '0;
      r_cnt    <= '0;
      active   <= 1'b0;
      mode     <= '0;
      err      <= 1'b0;
      locked   <= 1'b0;
      fail_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_KEY: begin
          if (valid_cmd) begin
            if (r_state == S_IDLE) begin
              active <= 1'b0;
              mode   <= '0;
              err    <= 1'b0;
            end
            r_key <= w_key_next;
            r_cnt <= w_cnt_next;
            if (w_cnt_next == KEY_LAST) begin
              r_state <= S_MODE;
              r_msh   <= '0;
            end else begin
              r_state <= S_KEY;
            end
          end
        end
        S_MODE: begin
          if (valid_cmd) begin
            r_msh <= w_mode_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt + CW'(1) == CMD_LAST) begin
              mode     <= w_mode_next;
              active   <= 1'b1;
              fail_cnt <= '0;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE, S_FAIL: begin
          // Stay here while valid_cmd is held so extra bits are ignored.
          if (!valid_cmd) r_state <= S_IDLE;
        end
        S_LOCK: begin
          locked   <= 1'b1;
          err      <= 1'b1;
          active   <= 1'b0;
          fail_cnt <= FAIL_MAX;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_fail) begin
        err      <= 1'b1;
        active   <= 1'b0;
        r_key    <= '0;
        r_msh    <= '0;
        r_cnt    <= '0;
        fail_cnt <= w_fail_inc;
        if (w_fail_inc == FAIL_MAX) begin
          locked  <= 1'b1;
          r_state <= S_LOCK;
        end else begin
          r_state <= S_FAIL;
        end
      end
    end
  end

endmodule
